max_div7_result_checker: RTL and testbench
==========================================

Name: max_div7_result_checker

Overview:
- Downstream consumer of the largest-number-divisible-by-7 finder.
- Waits for the finder's done indications (Qdf / Qdnf), latches its Max result and returns the Ack handshake.
- Independently recomputes Max/7 by repeated subtraction, producing the quotient and a remainder-zero check.
- Holds the checked result until the user acknowledges it, then re-arms for the next run.

Parameters:
- DIVISOR, 7, constant subtracted per SUB cycle (8-bit; must be non-zero)
- QW, 6, quotient width (ceil(log2(255/7+1)) = 6)

Ports:
- Clk  input  1  system clock, rising edge
- Reset  input  1  asynchronous, active-low reset (Reset = 0 resets the block)
- Max  input  8  result from upstream finder; valid only while Qdf = 1
- Qdf  input  1  upstream "done, found" state flag
- Qdnf  input  1  upstream "done, not found" state flag
- Ack  output  1  acknowledge to upstream finder
- UAck  input  1  user acknowledge; releases DONE
- Quot  output  QW  Max / DIVISOR
- Rem_ok  output  1  1 = remainder of Max / DIVISOR is zero
- Found  output  1  1 = upstream reported found; 0 = not found
- Run_count  output  8  completed captures, saturating at 255
- Qidle, Qack, Qsub, Qdone  output  1 each  one-hot state flags

Behaviour:
- Reset (Reset = 0, async):
  - state = IDLE; Quot = 0; Rem_ok = 0; Found = 0; Run_count = 0; internal X = 0.
  - Ack is low whenever the block is in reset.
- State encoding: one-hot, 4 bits, {Qdone, Qsub, Qack, Qidle} = state.
- IDLE:
  - If Qdf = 1: X <= Max; Quot <= 0; Found <= 1; Rem_ok <= 0; next state = ACK.
  - Else if Qdnf = 1: X <= 0; Quot <= 0; Found <= 0; Rem_ok <= 0; next state = ACK.
  - Qdf and Qdnf both high is illegal upstream behaviour; Qdf has priority.
  - Run_count increments on either capture and saturates at 8'hFF.
- ACK:
  - Ack = 1, combinational decode of state = ACK; high for exactly one cycle.
  - Upstream samples Ack on the same edge on which this block leaves ACK.
  - Next state = SUB if Found = 1, else DONE.
  - Max is not re-sampled after IDLE.
- SUB, one subtraction per cycle:
  - If X >= DIVISOR: X <= X - DIVISOR; Quot <= Quot + 1; stay in SUB.
  - Else: Rem_ok <= (X == 0); next state = DONE.
  - Cycles spent in SUB = floor(Max/7) + 1; worst case Max = 252 gives 37 cycles.
  - Compare is unsigned 8-bit; X never underflows.
- DONE:
  - Quot, Rem_ok and Found are stable; Qdone = 1.
  - UAck = 1 -> next state IDLE; outputs hold their values until the next capture.
  - A not-found run ends with Found = 0, Quot = 0, Rem_ok = 0.
- Latency from the Qdf edge to Qdone = 1: 2 + floor(Max/7) + 1 cycles.
- Qdf or Qdnf seen outside IDLE: ignored; no second capture occurs until IDLE is re-entered.
- Qdf held high through DONE -> IDLE: a new capture occurs. Upstream returns to its initial state on Ack, so this cannot happen with a conforming finder.
- Max = 0 with Qdf: Quot = 0, Rem_ok = 1. This flags a protocol violation, since the finder reports non-zero values only.
- Reset asserted mid-SUB: immediate return to IDLE with all outputs cleared; the partial quotient is discarded.
- Outputs are registered except Ack and the state flags, which are decoded from the state register only; no input-to-output combinational path exists.

Decomposition:
- Shared package:
  - state localparams IDLE = 4'b0001, ACK = 4'b0010, SUB = 4'b0100, DONE = 4'b1000;
  - DIVISOR constant;
  - QW width constant.
- The package is reusable by the finder's testbench for the state-flag checks.
- Single always block containing the control unit and data unit. No sub-module is warranted: the subtractor/compare is a single expression.

Test Plan:
- Reset low mid-run, then release -> Qidle = 1, Quot = 0, Rem_ok = 0, Found = 0, Run_count = 0, Ack = 0.
- Qdf = 1 with Max = 8'd98 -> Ack high for one cycle; then 15 SUB cycles; then DONE with Quot = 14, Rem_ok = 1, Found = 1, Run_count = 1.
- Qdnf = 1 (Max = X) -> ACK, then DONE the cycle after; Found = 0, Quot = 0, Rem_ok = 0; Qsub never asserted.
- Qdf with Max = 8'd100 -> Quot = 14, Rem_ok = 0 (remainder 2); checker must flag it as a finder error.
- Qdf with Max = 8'd252 -> DONE after 37 SUB cycles; Quot = 36, Rem_ok = 1. Then UAck = 1 -> IDLE.
- Repeat the Max = 98 run 257 times -> Run_count saturates at 255. Separately, assert Qdf and Qdnf together -> Found = 1 (Qdf priority).

Source files
------------

// File: rtl/max_div7_result_checker_pkg.sv
// Shared constants and state encoding for the divisible-by-7 result checker.
// The finder's testbench can import this package to decode the checker's state flags.
package max_div7_result_checker_pkg;

  // One-hot state codes. Bit order matches {Qdone, Qsub, Qack, Qidle}.
  localparam logic [3:0] IDLE = 4'b0001;
  localparam logic [3:0] ACK  = 4'b0010;
  localparam logic [3:0] SUB  = 4'b0100;
  localparam logic [3:0] DONE = 4'b1000;

  // Divisor subtracted once per SUB cycle. It must be non-zero, or SUB never exits.
  localparam logic [7:0] DIVISOR = 8'd7;

  // Quotient width: 255/7 = 36 fits in 6 bits.
  localparam int QW = 6;

  typedef enum logic [3:0] {
    S_IDLE = IDLE,
    S_ACK  = ACK,
    S_SUB  = SUB,
    S_DONE = DONE
  } state_t;

endpackage

// File: rtl/max_div7_result_checker.sv
// Consumer of the largest-divisible-by-7 finder. It latches Max when the finder
// reports done and returns Ack. It then recomputes Max/DIVISOR by repeated
// subtraction and holds the quotient and remainder check until the user acknowledges.
module max_div7_result_checker
  import max_div7_result_checker_pkg::*;
(
  input  logic          Clk,
  input  logic          Reset,
  input  logic [7:0]    Max,
  input  logic          Qdf,
  input  logic          Qdnf,
  output logic          Ack,
  input  logic          UAck,
  output logic [QW-1:0] Quot,
  output logic          Rem_ok,
  output logic          Found,
  output logic [7:0]    Run_count,
  output logic          Qidle,
  output logic          Qack,
  output logic          Qsub,
  output logic          Qdone
);

  state_t        state_q, state_d;
  logic [7:0]    x_q, x_d;
  logic [QW-1:0] quot_q, quot_d;
  logic          rem_ok_q, rem_ok_d;
  logic          found_q, found_d;
  logic [7:0]    run_count_q, run_count_d;

  // Next-state and datapath update: capture in IDLE, then one subtraction per SUB cycle.
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    quot_d      = quot_q;
    rem_ok_d    = rem_ok_q;
    found_d     = found_q;
    run_count_d = run_count_q;
    case (state_q)
      S_IDLE: begin
        // Qdf wins if the finder illegally raises both flags.
        if (Qdf || Qdnf) begin
          x_d         = Qdf ? Max : 8'd0;
          quot_d      = '0;
          found_d     = Qdf;
          rem_ok_d    = 1'b0;
          run_count_d = (run_count_q == 8'hFF) ? run_count_q : run_count_q + 8'd1;
          state_d     = S_ACK;
        end
      end
      S_ACK: begin
        // A not-found run has nothing to divide and goes straight to DONE.
        state_d = found_q ? S_SUB : S_DONE;
      end
      S_SUB: begin
        // An unsigned compare before subtracting keeps X from underflowing.
        if (x_q >= DIVISOR) begin
          x_d    = x_q - DIVISOR;
          quot_d = quot_q + QW'(1);
        end else begin
          rem_ok_d = (x_q == 8'd0);
          state_d  = S_DONE;
        end
      end
      S_DONE: begin
        if (UAck) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and result registers; reset discards any partial quotient.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      x_q         <= 8'd0;
      quot_q      <= '0;
      rem_ok_q    <= 1'b0;
      found_q     <= 1'b0;
      run_count_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      quot_q      <= quot_d;
      rem_ok_q    <= rem_ok_d;
      found_q     <= found_d;
      run_count_q <= run_count_d;
    end
  end

  // Ack and the flags decode only the state register. Reset forces IDLE, so Ack is low in reset.
  assign Ack                        = (state_q == S_ACK);
  assign {Qdone, Qsub, Qack, Qidle} = state_q;
  assign Quot                       = quot_q;
  assign Rem_ok                     = rem_ok_q;
  assign Found                      = found_q;
  assign Run_count                  = run_count_q;

endmodule

// File: tb/tb_max_div7_result_checker.sv
// Directed and randomized bench for max_div7_result_checker. Expected results
// come from plain integer division and modulo on the captured Max value.
module tb_max_div7_result_checker;

  logic       Clk;
  logic       Reset;
  logic [7:0] Max;
  logic       Qdf, Qdnf, UAck;
  logic       Ack;
  logic [5:0] Quot;
  logic       Rem_ok, Found;
  logic [7:0] Run_count;
  logic       Qidle, Qack, Qsub, Qdone;

  int checks = 0;
  int errors = 0;
  int rc_exp = 0;

  max_div7_result_checker dut (
    .Clk(Clk), .Reset(Reset), .Max(Max), .Qdf(Qdf), .Qdnf(Qdnf), .Ack(Ack),
    .UAck(UAck), .Quot(Quot), .Rem_ok(Rem_ok), .Found(Found),
    .Run_count(Run_count), .Qidle(Qidle), .Qack(Qack), .Qsub(Qsub), .Qdone(Qdone)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge so outputs are settled.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  // One complete capture, compute and DONE sequence, checked against the arithmetic model.
  task automatic do_run(input logic [7:0] m, input logic df, input logic dnf,
                        input bit verbose);
    logic exp_found;
    int   n;
    bit   done;
    exp_found = df;
    Max = m; Qdf = df; Qdnf = dnf;
    step();
    Qdf = 1'b0; Qdnf = 1'b0;
    Max = 8'($urandom);  // Max must not be re-sampled after capture
    rc_exp = (rc_exp == 255) ? 255 : rc_exp + 1;
    if (verbose) begin
      chk("ack_high", Ack, 1);
      chk("qack", Qack, 1);
    end
    n = 0; done = 0;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (i == 0 && verbose) chk("ack_one_cycle", Ack, 0);
      if (Qsub) n++;
      if (Qdone) done = 1;
    end
    chk("reached_done", done, 1);
    if (verbose) chk("sub_cycles", n, exp_found ? (m / 7) + 1 : 0);
    chk("quot", Quot, exp_found ? (m / 7) : 0);
    chk("rem_ok", Rem_ok, exp_found ? ((m % 7) == 0) : 0);
    chk("found", Found, exp_found);
    chk("run_count", Run_count, rc_exp);
  endtask

  task automatic user_ack();
    logic [5:0] q;
    q = Quot;
    UAck = 1'b1;
    step();
    UAck = 1'b0;
    chk("idle_after_uack", Qidle, 1);
    chk("quot_held", Quot, q);
  endtask

  initial begin
    Reset = 1'b1; Max = 8'd0; Qdf = 1'b0; Qdnf = 1'b0; UAck = 1'b0;
    #3 Reset = 1'b0;
    repeat (2) step();
    chk("rst_qidle", Qidle, 1);
    chk("rst_ack", Ack, 0);
    Reset = 1'b1;
    step();

    // Found run with an exact multiple.
    do_run(8'd98, 1'b1, 1'b0, 1'b1);
    user_ack();

    // Not-found run: Max is ignored, and SUB is never entered.
    do_run(8'hA5, 1'b0, 1'b1, 1'b1);
    user_ack();

    // A non-multiple means the finder made an error.
    do_run(8'd100, 1'b1, 1'b0, 1'b1);
    if (Rem_ok == 1'b0) $display("note: finder error flagged for Max=100");
    user_ack();

    // Worst case. A Qdf pulse while in DONE must be ignored.
    do_run(8'd252, 1'b1, 1'b0, 1'b1);
    Max = 8'd5; Qdf = 1'b1;
    step();
    Qdf = 1'b0;
    chk("done_ignores_qdf", Qdone, 1);
    chk("done_no_recount", Run_count, rc_exp);
    chk("done_quot_hold", Quot, 36);
    user_ack();

    // Max = 0 gives quotient 0 with a zero remainder.
    do_run(8'd0, 1'b1, 1'b0, 1'b1);
    user_ack();

    // Both done flags high: Qdf has priority.
    do_run(8'd49, 1'b1, 1'b1, 1'b1);
    user_ack();

    // Randomized runs.
    for (int k = 0; k < 20; k++) begin
      logic [7:0] rm;
      logic       rf;
      rm = 8'($urandom_range(0, 255));
      rf = 1'($urandom_range(0, 1));
      do_run(rm, rf, ~rf, 1'b1);
      user_ack();
    end

    // Reset asserted mid-SUB clears everything at once.
    Max = 8'd252; Qdf = 1'b1;
    step();
    Qdf = 1'b0;
    repeat (10) step();
    chk("mid_sub_busy", Qsub, 1);
    Reset = 1'b0;
    #1;
    chk("mrst_qidle", Qidle, 1);
    chk("mrst_quot", Quot, 0);
    chk("mrst_rem_ok", Rem_ok, 0);
    chk("mrst_found", Found, 0);
    chk("mrst_run_count", Run_count, 0);
    chk("mrst_ack", Ack, 0);
    step();
    Reset = 1'b1;
    rc_exp = 0;
    step();
    chk("post_rst_idle", Qidle, 1);

    // Run_count saturates at 255 after 257 captures.
    for (int k = 0; k < 257; k++) begin
      do_run(8'd98, 1'b1, 1'b0, 1'b0);
      user_ack();
    end
    chk("run_count_sat", Run_count, 255);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
